// File: rtl/associative_counter_table.sv
// Fully-associative key/value table with lookup, insert/update, saturating increment and delete.
// Every op searches all valid slots in parallel and returns a registered response one cycle later.
module associative_counter_table #(
    parameter  int KEY_WIDTH  = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int ENTRIES    = 4,
    localparam int IDX_W      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  flush,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    input  logic [KEY_WIDTH-1:0]  key,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [IDX_W-1:0]      rsp_index,
    output logic                  rsp_error,
    output logic [IDX_W:0]        count,
    output logic                  full
);

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_INC    = 2'b10,
        OP_DELETE = 2'b11
    } op_e;

    localparam logic [DATA_WIDTH-1:0] DATA_MAX = '1;

    logic [ENTRIES-1:0]    valid_q;
    logic [KEY_WIDTH-1:0]  key_q  [ENTRIES];
    logic [DATA_WIDTH-1:0] data_q [ENTRIES];

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  has_free;
    logic [IDX_W-1:0]      free_idx;
    logic [DATA_WIDTH-1:0] hit_data;

    logic                  do_alloc;
    logic                  do_write;
    logic                  do_delete;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  nxt_hit;
    logic                  nxt_error;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [IDX_W-1:0]      nxt_index;
    logic [IDX_W:0]        nxt_count;

    // Scan downward so the lowest-index match and lowest free slot win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign hit_data = data_q[hit_idx];

    always_comb begin
        do_alloc  = 1'b0;
        do_write  = 1'b0;
        do_delete = 1'b0;
        wr_idx    = hit_idx;
        wr_data   = data_in;
        nxt_hit   = hit;
        nxt_error = 1'b0;
        nxt_data  = '0;
        nxt_index = '0;
        nxt_count = count;
        case (op_e'(op))
            OP_LOOKUP: begin
                if (hit) begin
                    nxt_data  = hit_data;
                    nxt_index = hit_idx;
                end
            end
            OP_INSERT: begin
                if (hit) begin
                    do_write  = 1'b1;
                    nxt_data  = data_in;
                    nxt_index = hit_idx;
                end else if (has_free) begin
                    do_alloc  = 1'b1;
                    do_write  = 1'b1;
                    wr_idx    = free_idx;
                    nxt_data  = data_in;
                    nxt_index = free_idx;
                    nxt_count = count + (IDX_W + 1)'(1);
                end else begin
                    nxt_error = 1'b1;
                end
            end
            OP_INC: begin
                if (hit) begin
                    nxt_index = hit_idx;
                    if (hit_data == DATA_MAX) begin
                        nxt_error = 1'b1;
                        nxt_data  = hit_data;
                    end else begin
                        do_write  = 1'b1;
                        wr_data   = hit_data + DATA_WIDTH'(1);
                        nxt_data  = hit_data + DATA_WIDTH'(1);
                    end
                end
            end
            OP_DELETE: begin
                if (hit) begin
                    do_delete = 1'b1;
                    nxt_data  = hit_data;
                    nxt_index = hit_idx;
                    nxt_count = count - (IDX_W + 1)'(1);
                end
            end
            default: ;
        endcase
    end

    // Flush drops any op issued in the same cycle, so no response follows it.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            valid_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
            count     <= '0;
            full      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= '0;
            rsp_index <= '0;
        end else if (flush) begin
            valid_q   <= '0;
            count     <= '0;
            full      <= 1'b0;
            rsp_valid <= 1'b0;
        end else if (op_valid) begin
            if (do_write) begin
                data_q[wr_idx] <= wr_data;
            end
            if (do_alloc) begin
                key_q[wr_idx]   <= key;
                valid_q[wr_idx] <= 1'b1;
            end
            if (do_delete) begin
                valid_q[hit_idx] <= 1'b0;
            end
            count     <= nxt_count;
            full      <= (nxt_count == (IDX_W + 1)'(ENTRIES));
            rsp_valid <= 1'b1;
            rsp_hit   <= nxt_hit;
            rsp_error <= nxt_error;
            rsp_data  <= nxt_data;
            rsp_index <= nxt_index;
        end else begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_associative_counter_table.sv
// Directed self-checking bench for associative_counter_table with hand-computed expectations.
module tb_associative_counter_table;

    localparam int KW = 4;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] INSERT = 2'b01;
    localparam logic [1:0] INC    = 2'b10;
    localparam logic [1:0] DELETE = 2'b11;

    logic          clk;
    logic          async_reset;
    logic          flush;
    logic          op_valid;
    logic [1:0]    op;
    logic [KW-1:0] key;
    logic [DW-1:0] data_in;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [DW-1:0] rsp_data;
    logic [IW-1:0] rsp_index;
    logic          rsp_error;
    logic [IW:0]   count;
    logic          full;

    int checks = 0;
    int errors = 0;

    associative_counter_table #(
        .KEY_WIDTH (KW),
        .DATA_WIDTH(DW),
        .ENTRIES   (N)
    ) dut (
        .clk        (clk),
        .async_reset(async_reset),
        .flush      (flush),
        .op_valid   (op_valid),
        .op         (op),
        .key        (key),
        .data_in    (data_in),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_data   (rsp_data),
        .rsp_index  (rsp_index),
        .rsp_error  (rsp_error),
        .count      (count),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drives one op for a single edge, then leaves the response settled for checking.
    task automatic applyStimulus(input logic [1:0] o, input logic [KW-1:0] k, input logic [DW-1:0] d);
        op       = o;
        key      = k;
        data_in  = d;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic checkRsp(input string tag, input logic hit, input logic [DW-1:0] d,
                            input logic [IW-1:0] idx, input logic err);
        checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_hit"},   32'(rsp_hit),   32'(hit));
        checkOutput({tag, "_data"},  32'(rsp_data),  32'(d));
        checkOutput({tag, "_index"}, 32'(rsp_index), 32'(idx));
        checkOutput({tag, "_error"}, 32'(rsp_error), 32'(err));
    endtask

    initial begin
        async_reset = 1'b1;
        flush       = 1'b0;
        op_valid    = 1'b0;
        op          = LOOKUP;
        key         = '0;
        data_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_full",  32'(full), 32'd0);
        checkOutput("reset_data",  32'(rsp_data), 32'd0);
        async_reset = 1'b0;

        applyStimulus(LOOKUP, 4'd3, 8'd0);
        checkRsp("lookup_empty", 1'b0, 8'd0, 2'd0, 1'b0);
        checkOutput("lookup_empty_count", 32'(count), 32'd0);
        checkOutput("lookup_empty_full",  32'(full), 32'd0);

        applyStimulus(INSERT, 4'd5, 8'd10);
        checkRsp("ins5", 1'b0, 8'd10, 2'd0, 1'b0);
        applyStimulus(INSERT, 4'd6, 8'd20);
        checkRsp("ins6", 1'b0, 8'd20, 2'd1, 1'b0);
        applyStimulus(INSERT, 4'd7, 8'd30);
        checkRsp("ins7", 1'b0, 8'd30, 2'd2, 1'b0);
        checkOutput("ins7_full", 32'(full), 32'd0);
        applyStimulus(INSERT, 4'd8, 8'd40);
        checkRsp("ins8", 1'b0, 8'd40, 2'd3, 1'b0);
        checkOutput("fill_count", 32'(count), 32'd4);
        checkOutput("fill_full",  32'(full), 32'd1);

        applyStimulus(INSERT, 4'd9, 8'd1);
        checkRsp("ins_full", 1'b0, 8'd0, 2'd0, 1'b1);
        checkOutput("ins_full_count", 32'(count), 32'd4);

        applyStimulus(DELETE, 4'd6, 8'd0);
        checkRsp("del6", 1'b1, 8'd20, 2'd1, 1'b0);
        checkOutput("del6_count", 32'(count), 32'd3);
        checkOutput("del6_full",  32'(full), 32'd0);

        applyStimulus(LOOKUP, 4'd6, 8'd0);
        checkRsp("lookup_deleted", 1'b0, 8'd0, 2'd0, 1'b0);

        applyStimulus(INSERT, 4'd9, 8'd99);
        checkRsp("ins9", 1'b0, 8'd99, 2'd1, 1'b0);
        checkOutput("ins9_count", 32'(count), 32'd4);
        applyStimulus(LOOKUP, 4'd9, 8'd0);
        checkRsp("lookup9", 1'b1, 8'd99, 2'd1, 1'b0);

        @(posedge clk);
        #1;
        checkOutput("idle_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_hold",  32'(rsp_data), 32'd99);

        applyStimulus(DELETE, 4'd5, 8'd0);
        checkRsp("del5", 1'b1, 8'd10, 2'd0, 1'b0);
        applyStimulus(INSERT, 4'd5, 8'hFD);
        checkRsp("ins5_fd", 1'b0, 8'hFD, 2'd0, 1'b0);
        applyStimulus(INC, 4'd5, 8'd0);
        checkRsp("inc1", 1'b1, 8'hFE, 2'd0, 1'b0);
        applyStimulus(INC, 4'd5, 8'd0);
        checkRsp("inc2", 1'b1, 8'hFF, 2'd0, 1'b0);
        applyStimulus(INC, 4'd5, 8'd0);
        checkRsp("inc_sat", 1'b1, 8'hFF, 2'd0, 1'b1);
        applyStimulus(INC, 4'hA, 8'd0);
        checkRsp("inc_miss", 1'b0, 8'd0, 2'd0, 1'b0);
        checkOutput("inc_miss_count", 32'(count), 32'd4);

        applyStimulus(INC, 4'd7, 8'd0);
        checkRsp("inc7", 1'b1, 8'd31, 2'd2, 1'b0);

        applyStimulus(INSERT, 4'd5, 8'd7);
        checkRsp("upd5_a", 1'b1, 8'd7, 2'd0, 1'b0);
        applyStimulus(INSERT, 4'd5, 8'd11);
        checkRsp("upd5_b", 1'b1, 8'd11, 2'd0, 1'b0);
        checkOutput("upd5_count", 32'(count), 32'd4);
        applyStimulus(LOOKUP, 4'd5, 8'd0);
        checkRsp("lookup5", 1'b1, 8'd11, 2'd0, 1'b0);

        applyStimulus(DELETE, 4'hB, 8'd0);
        checkRsp("del_miss", 1'b0, 8'd0, 2'd0, 1'b0);
        checkOutput("del_miss_count", 32'(count), 32'd4);

        flush    = 1'b1;
        op       = INSERT;
        key      = 4'hC;
        data_in  = 8'h55;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_valid = 1'b0;
        checkOutput("flush_valid", 32'(rsp_valid), 32'd0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_full",  32'(full), 32'd0);
        applyStimulus(LOOKUP, 4'd7, 8'd0);
        checkRsp("flush_lookup7", 1'b0, 8'd0, 2'd0, 1'b0);
        applyStimulus(LOOKUP, 4'hC, 8'd0);
        checkRsp("flush_lookupC", 1'b0, 8'd0, 2'd0, 1'b0);

        applyStimulus(INSERT, 4'd3, 8'h33);
        checkRsp("ins3", 1'b0, 8'h33, 2'd0, 1'b0);
        applyStimulus(INSERT, 4'd4, 8'h44);
        checkRsp("ins4", 1'b0, 8'h44, 2'd1, 1'b0);
        checkOutput("ins4_count", 32'(count), 32'd2);

        #2;
        async_reset = 1'b1;
        #1;
        checkOutput("async_valid", 32'(rsp_valid), 32'd0);
        checkOutput("async_data",  32'(rsp_data), 32'd0);
        checkOutput("async_index", 32'(rsp_index), 32'd0);
        checkOutput("async_count", 32'(count), 32'd0);
        @(negedge clk);
        async_reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_valid", 32'(rsp_valid), 32'd0);
        applyStimulus(LOOKUP, 4'd3, 8'd0);
        checkRsp("post_reset_lookup", 1'b0, 8'd0, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/associative_counter_table.md
# associative_counter_table

Parametrised fully-associative key/value table, generalising the direct-indexed associative buffer. Each op (lookup, insert/update, saturating increment, delete) matches an incoming key against all valid entries in parallel. Each accepted op returns a registered response one cycle later, with hit, data, index and error status. Insertion fills the lowest free slot, and occupancy and full status are reported continuously. It sits between a command source and any logic that needs keyed counters, such as per-ID event tallies.

## Interface
- KEY_WIDTH, 4, key bits per entry
- DATA_WIDTH, 8, stored value bits per entry
- ENTRIES, 4, number of table slots, ≥2; IDX_W = $clog2(ENTRIES)
- clk  in  1  clock; all state changes on the rising edge
- async_reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all valid bits
- op_valid  in  1  op present this cycle; always accepted, no backpressure
- op  in  2  00 LOOKUP, 01 INSERT, 10 INC, 11 DELETE
- key  in  KEY_WIDTH  match key
- data_in  in  DATA_WIDTH  value for INSERT
- rsp_valid  out  1  response strobe, exactly one cycle per accepted op
- rsp_hit  out  1  key matched a valid entry when the op was sampled
- rsp_data  out  DATA_WIDTH  entry value after the op; 0 on miss
- rsp_index  out  IDX_W  matched or allocated slot; 0 if none
- rsp_error  out  1  INSERT miss while full, or INC of a saturated entry
- count  out  IDX_W+1  number of valid entries
- full  out  1  count == ENTRIES

## Operation
- Storage per slot: valid bit, key reg, data reg. Match vector = valid & (key_reg == key), computed combinationally.
- Keys are unique by construction, so at most one match exists. If the invariant is broken, the lowest matching index is used.
- LOOKUP: no state change. Hit returns the stored data and index.
- INSERT on hit: overwrite data, rsp_hit=1. INSERT on miss with a free slot: write key/data into the lowest-index invalid slot and set valid; rsp_hit=0, rsp_index=that slot, rsp_data=data_in. INSERT on miss when full: no change, rsp_error=1.
- INC on hit: data+1, saturating at all-ones. If the entry is already all-ones, data is unchanged and rsp_error=1. INC on miss: no change, rsp_hit=0, no error, no allocation.
- DELETE on hit: clear valid. Key and data regs are left untouched; rsp_data returns the value held before deletion. DELETE on miss: no change.
- count and full are registered and updated in the same edge as the valid bits: +1 on allocation, −1 on delete hit, 0 on flush.
- flush has priority over op_valid. When both are high, the op is dropped and no response is produced (rsp_valid=0 next cycle).
- All arithmetic is unsigned DATA_WIDTH; there is no wrap-around on INC.

## Timing
- Reset (async_reset=1, immediate): all valid=0, count=0, full=0, rsp_valid=0, rsp_hit=0, rsp_error=0, rsp_data=0, rsp_index=0. Key and data regs are reset to 0.
- Reset asserted mid-operation discards any pending response. The first response after release is for an op sampled after release.
- Latency: an op sampled at edge N updates the table at edge N, and its response is visible after edge N (registered). Throughput is one op per cycle.
- Back-to-back ops see the table state left by the previous op. For example, INSERT k then LOOKUP k in consecutive cycles gives a hit.
- rsp_* outputs hold their values while rsp_valid=0. Consumers must qualify with rsp_valid.

## Test plan
- Reset, then LOOKUP key 3 → rsp_valid=1, rsp_hit=0, rsp_data=0, count=0, full=0.
- INSERT keys 5,6,7,8 with data 10,20,30,40 → rsp_index 0,1,2,3; then full=1, count=4. INSERT key 9 → rsp_error=1, count stays 4.
- INSERT 5/0xFD, then INC 5 three times → rsp_data FE, FF, FF; the third INC gives rsp_error=1.
- Fill the table, DELETE key 6 (index 1) → rsp_data=20, count=3. INSERT key 9/99 → rsp_index=1. LOOKUP 9 → rsp_data=99.
- INSERT 5/7, then INSERT 5/11 → second op rsp_hit=1 with no new allocation (count unchanged). LOOKUP 5 → rsp_data=11.
- Assert flush together with op_valid INSERT → no rsp_valid next cycle, count=0, LOOKUP of any prior key misses. Assert async_reset between clock edges → outputs go to 0 without waiting for a clock edge.
